fifo_rr_scheduler: RTL

// - Drain scheduler for NUM_Q byte FIFOs (8-bit data, registered read data, registered empty flag).
// - Picks one non-empty, enabled queue per cycle by round-robin with bounded bursts.
// - Pulses that queue's read strobe and merges the returned bytes into one valid/ready stream tagged with queue id.
// - Sits between the per-source FIFO bank and the single downstream byte consumer.

---
 rtl/fifo_sched_pkg.sv | 24 ++
 rtl/fifo_rr_scheduler_if.sv | 30 +++
 rtl/fifo_rr_pick.sv | 38 +++
 rtl/fifo_rr_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types for the FIFO round-robin drain scheduler.
//   state_t      : scheduler FSM states
//   qid_w()      : width of a queue index for a given queue count
//   skid_entry_t : one buffered output byte with its source queue id
package fifo_sched_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned QID_MAX_W = 8;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  function automatic int unsigned qid_w(input int unsigned num_q);
    return (num_q > 1) ? $clog2(num_q) : 1;
  endfunction

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [QID_MAX_W-1:0] qid;
  } skid_entry_t;

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// Bundle between the FIFO bank, the scheduler and the downstream consumer.
//   master : scheduler side (drives read strobes and the output stream)
//   slave  : environment side (FIFO bank status/data and consumer ready)
interface fifo_rr_scheduler_if
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NUM_Q = 4,
  parameter int unsigned QID_W = qid_w(NUM_Q)
);

  logic [NUM_Q-1:0]             in_q_enable;
  logic [NUM_Q-1:0]             in_q_empty;
  logic [NUM_Q-1:0]             out_q_read;
  logic [NUM_Q-1:0][DATA_W-1:0] in_q_data;
  logic                         out_valid;
  logic                         in_ready;
  logic [DATA_W-1:0]            out_data;
  logic [QID_W-1:0]             out_qid;

  modport master (
    input  in_q_enable, in_q_empty, in_q_data, in_ready,
    output out_q_read, out_valid, out_data, out_qid
  );

  modport slave (
    output in_q_enable, in_q_empty, in_q_data, in_ready,
    input  out_q_read, out_valid, out_data, out_qid
  );

endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker.
//   eligible : per-queue request mask
//   last     : most recently served index; search starts just after it
//   pick     : one-hot selected queue (zero when none)
//   pick_idx : index of selected queue
//   any      : at least one queue eligible
module fifo_rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NUM_Q = 4,
  parameter int unsigned QID_W = qid_w(NUM_Q)
) (
  input  logic [NUM_Q-1:0] eligible,
  input  logic [QID_W-1:0] last,
  output logic [NUM_Q-1:0] pick,
  output logic [QID_W-1:0] pick_idx,
  output logic             any
);

  logic [QID_W-1:0] cand;

  // The search visits last+1 .. last+NUM_Q, so 'last' itself is checked last.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_Q; k++) begin
      cand = QID_W'((32'(last) + k) % NUM_Q);
      if (!any && eligible[cand]) begin
        any      = 1'b1;
        pick_idx = cand;
      end
    end
    pick[pick_idx] = any;
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drain scheduler for NUM_Q byte FIFOs: round-robin with bounded bursts,
// merging returned bytes into one valid/ready stream tagged with queue id.
//   clk, rst : clock, synchronous active-high reset
//   bus      : master side of fifo_rr_scheduler_if (strobes, data, stream)
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NUM_Q     = 4,
  parameter int unsigned BURST_MAX = 4
) (
  input logic                 clk,
  input logic                 rst,
  fifo_rr_scheduler_if.master bus
);

  localparam int unsigned QID_W = qid_w(NUM_Q);
  localparam int unsigned BC_W  = $clog2(BURST_MAX + 1);

  state_t            state, state_nx;
  logic [QID_W-1:0]  grant, grant_nx;
  logic [QID_W-1:0]  rr_ptr, rr_ptr_nx;
  logic [BC_W-1:0]   burst, burst_nx;

  logic [NUM_Q-1:0]  eligible;
  logic [QID_W-1:0]  pick_last;
  logic [NUM_Q-1:0]  pick_oh;
  logic [QID_W-1:0]  pick_idx;
  logic              pick_any;

  logic              credit;
  logic              read_en;
  logic [QID_W-1:0]  read_idx;
  logic [NUM_Q-1:0]  read_vec;

  logic              inflight;
  logic [QID_W-1:0]  inflight_qid;
  logic [DATA_W-1:0] cap_data;

  skid_entry_t       skid_mem [2];
  skid_entry_t       skid_head;
  logic              skid_rd, skid_wr;
  logic [1:0]        skid_cnt;
  logic              accept, push, pop;
  logic              unused_qid_bits;

  assign eligible  = bus.in_q_enable & ~bus.in_q_empty;
  assign pick_last = (state == S_BURST) ? grant : rr_ptr;

  fifo_rr_pick #(
    .NUM_Q (NUM_Q),
    .QID_W (QID_W)
  ) u_pick (
    .eligible (eligible),
    .last     (pick_last),
    .pick     (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // Every issued read has a guaranteed slot: skid plus in-flight never exceeds 2.
  assign credit = (32'(skid_cnt) + 32'(inflight)) < 2;

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    rr_ptr_nx = rr_ptr;
    burst_nx  = burst;
    read_en   = 1'b0;
    read_idx  = grant;
    read_vec  = '0;
    case (state)
      S_IDLE: begin
        if (credit && pick_any) begin
          read_en  = 1'b1;
          read_idx = pick_idx;
          read_vec = pick_oh;
          grant_nx = pick_idx;
          burst_nx = BC_W'(1);
          state_nx = S_BURST;
        end
      end
      S_BURST: begin
        if (credit) begin
          if (eligible[grant] && (burst < BC_W'(BURST_MAX))) begin
            read_en         = 1'b1;
            read_idx        = grant;
            read_vec[grant] = 1'b1;
            burst_nx        = burst + 1'b1;
          end else begin
            // Picker searches from the old grant, so a sole eligible grant is regranted.
            rr_ptr_nx = grant;
            if (pick_any) begin
              read_en  = 1'b1;
              read_idx = pick_idx;
              read_vec = pick_oh;
              grant_nx = pick_idx;
              burst_nx = BC_W'(1);
            end else begin
              burst_nx = '0;
              state_nx = S_IDLE;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.out_q_read = rst ? '0 : read_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      grant        <= '0;
      rr_ptr       <= QID_W'(NUM_Q - 1);
      burst        <= '0;
      inflight     <= 1'b0;
      inflight_qid <= '0;
      skid_rd      <= 1'b0;
      skid_wr      <= 1'b0;
      skid_cnt     <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      rr_ptr   <= rr_ptr_nx;
      burst    <= burst_nx;
      inflight <= read_en;
      if (read_en) begin
        inflight_qid <= read_idx;
      end
      if (push) begin
        skid_wr <= ~skid_wr;
      end
      if (pop) begin
        skid_rd <= ~skid_rd;
      end
      skid_cnt <= skid_cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      skid_mem[skid_wr] <= '{data: cap_data, qid: QID_MAX_W'(inflight_qid)};
    end
  end

  assign cap_data        = bus.in_q_data[inflight_qid];
  assign skid_head       = skid_mem[skid_rd];
  assign unused_qid_bits = ^skid_head.qid;

  // Returning byte bypasses the skid only when the skid is empty, preserving order.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_qid   = '0;
    if (skid_cnt != 2'd0) begin
      bus.out_valid = 1'b1;
      bus.out_data  = skid_head.data;
      bus.out_qid   = skid_head.qid[QID_W-1:0];
    end else if (inflight) begin
      bus.out_valid = 1'b1;
      bus.out_data  = cap_data;
      bus.out_qid   = inflight_qid;
    end
  end

  assign accept = bus.out_valid & bus.in_ready;
  assign push   = inflight & ~((skid_cnt == 2'd0) & accept);
  assign pop    = (skid_cnt != 2'd0) & accept;

endmodule
